// File: rtl/input_port_buffer.sv
// Router input-port buffer: circular flit FIFO with a packet FSM that requests the arbiter,
// holds the grant for a whole packet and discards orphan flits that arrive outside a packet.
`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL    3'b011
`endif

module input_port_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    in_flit,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     grant,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_flit,
    output logic                     out_valid,
    output logic                     req,
    output logic [2:0]               flit_id,
    output logic [11:0]              length,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [7:0]               drop_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    state_t                state_q, state_d;
    logic [11:0]           len_q;
    logic [7:0]            drop_q;

    logic                  empty, push, transfer, drop, pop;
    logic [DATA_WIDTH-1:0] head;
    logic [2:0]            head_id;

    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign head_id  = head[DATA_WIDTH-1:DATA_WIDTH-3];
    assign in_ready = (count < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;

    // Head-of-line decode: empty FIFO reports id 0, so length falls back to len_q.
    assign flit_id   = empty ? 3'b000 : head_id;
    assign req       = (state_q == ACTIVE) || (!empty && head_id == `HEADER);
    assign out_valid = req && grant && !empty;
    assign transfer  = out_valid && out_ready;
    assign drop      = (state_q == IDLE) && !empty && (head_id != `HEADER);
    assign pop       = transfer || drop;

    assign out_flit   = head;
    assign length     = (flit_id == `HEADER) ? head[11:0] : len_q;
    assign occupancy  = count;
    assign drop_count = drop_q;

    always_comb begin
        state_d = state_q;
        if (transfer) begin
            if (head_id == `HEADER)
                state_d = ACTIVE;
            else if (head_id == `TAIL)
                state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            len_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
            if (transfer && head_id == `HEADER)
                len_q <= head[11:0];
            if (drop)
                drop_q <= sat_inc(drop_q);
        end
    end

    // Flit storage carries no reset; only the pointers qualify its contents.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_flit;
    end

endmodule

// File: tb/tb_input_port_buffer.sv
// Bench for input_port_buffer: directed vector table, hand-written corner sequences and a
// randomized packet stream, all checked against a queue-based packet model.
`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL    3'b011
`endif

module tb_input_port_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam logic [2:0] HDR = `HEADER;
    localparam logic [2:0] PAY = `PAYLOAD;
    localparam logic [2:0] TL  = `TAIL;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_flit;
    logic          in_valid, in_ready, grant, out_ready;
    logic [DW-1:0] out_flit;
    logic          out_valid, req;
    logic [2:0]    flit_id;
    logic [11:0]   length;
    logic [3:0]    occupancy;
    logic [7:0]    drop_count;

    input_port_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .grant(grant), .out_ready(out_ready), .out_flit(out_flit), .out_valid(out_valid),
        .req(req), .flit_id(flit_id), .length(length), .occupancy(occupancy),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Packet-level model: stored flits in arrival order plus "inside a packet" flag.
    logic [DW-1:0] q[$];
    bit            m_active;
    logic [11:0]   m_len;
    int            m_drop;
    bit            checking;

    logic          e_req, e_ov, e_inr;
    logic [2:0]    e_id;
    logic [11:0]   e_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [2:0] id, input logic [11:0] len);
        logic [16:0] mid;
        mid = 17'($urandom);
        return {id, mid, len};
    endfunction

    // Compute expected outputs for the current state and inputs, compare at the negedge.
    task automatic sample();
        bit empty;
        @(negedge clk);
        empty = (q.size() == 0);
        e_id  = empty ? 3'b000 : q[0][DW-1:DW-3];
        e_req = m_active || (!empty && e_id == HDR);
        e_ov  = e_req && grant && !empty;
        e_inr = (q.size() < DEPTH);
        e_len = (e_id == HDR) ? q[0][11:0] : m_len;
        if (checking) begin
            chk("req", req, e_req);
            chk("out_valid", out_valid, e_ov);
            chk("in_ready", in_ready, e_inr);
            chk("flit_id", flit_id, e_id);
            chk("length", length, e_len);
            chk("occupancy", occupancy, q.size());
            chk("drop_count", drop_count, m_drop);
            if (e_ov) chk("out_flit", out_flit, q[0]);
        end
    endtask

    task automatic advance();
        logic [DW-1:0] f;
        bit empty;
        @(posedge clk);
        empty = (q.size() == 0);
        if (rst) begin
            q.delete();
            m_active = 0;
            m_len    = '0;
            m_drop   = 0;
        end else begin
            if (e_ov && out_ready) begin
                f = q.pop_front();
                if (f[DW-1:DW-3] == HDR) begin
                    m_active = 1;
                    m_len    = f[11:0];
                end else if (f[DW-1:DW-3] == TL) begin
                    m_active = 0;
                end
            end else if (!m_active && !empty && e_id != HDR) begin
                void'(q.pop_front());
                if (m_drop < 255) m_drop++;
            end
            if (in_valid && e_inr) q.push_back(in_flit);
        end
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic set_in(input logic v, input logic [DW-1:0] f, input logic g, input logic r);
        in_valid  = v;
        in_flit   = f;
        grant     = g;
        out_ready = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        vld;
        logic [2:0]  id;
        logic [11:0] len;
        logic        e_req;
        logic        e_ov;
        int          e_occ;
        logic [2:0]  e_fid;
        logic [11:0] e_len;
    } vec_t;

    vec_t tbl[6];
    logic [DW-1:0] src[$];
    int idx;

    initial begin
        // Header/payload/payload/tail with grant and out_ready held high.
        tbl[0] = '{1'b1, HDR, 12'd3,   1'b0, 1'b0, 0, 3'b000, 12'd0};
        tbl[1] = '{1'b1, PAY, 12'hABC, 1'b1, 1'b1, 1, HDR,    12'd3};
        tbl[2] = '{1'b1, PAY, 12'h123, 1'b1, 1'b1, 1, PAY,    12'd3};
        tbl[3] = '{1'b1, TL,  12'h456, 1'b1, 1'b1, 1, PAY,    12'd3};
        tbl[4] = '{1'b0, PAY, 12'h000, 1'b1, 1'b1, 1, TL,     12'd3};
        tbl[5] = '{1'b0, PAY, 12'h000, 1'b0, 1'b0, 0, 3'b000, 12'd3};

        q.delete();
        m_active = 0;
        m_len    = '0;
        m_drop   = 0;
        checking = 0;
        rst = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0);
        cyc();
        checking = 1;
        cyc();
        rst = 1'b0;
        cyc();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_req", req, 1'b0);
        chk("rst_length", length, 12'd0);

        for (int i = 0; i < 6; i++) begin
            set_in(tbl[i].vld, {tbl[i].id, 17'h0, tbl[i].len}, 1'b1, 1'b1);
            sample();
            chk($sformatf("tbl%0d_req", i), req, tbl[i].e_req);
            chk($sformatf("tbl%0d_ov", i), out_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].e_occ);
            chk($sformatf("tbl%0d_fid", i), flit_id, tbl[i].e_fid);
            chk($sformatf("tbl%0d_len", i), length, tbl[i].e_len);
            advance();
        end

        // Fill to DEPTH with the downstream stalled, then one pop with in_valid still high.
        set_in(1'b1, mk(HDR, 12'd0), 1'b1, 1'b0);
        cyc();
        for (int i = 1; i < DEPTH; i++) begin
            set_in(1'b1, mk(PAY, 12'($urandom)), 1'b1, 1'b0);
            cyc();
        end
        sample();
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_occ", occupancy, DEPTH);
        advance();
        set_in(1'b1, mk(TL, 12'd0), 1'b1, 1'b1);
        cyc();
        set_in(1'b0, '0, 1'b1, 1'b0);
        sample();
        chk("pop_when_full_occ", occupancy, DEPTH - 1);
        advance();
        set_in(1'b1, mk(TL, 12'd7), 1'b1, 1'b1);
        cyc();
        set_in(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 2 * DEPTH; i++) cyc();
        chk("drain_idle_req", req, 1'b0);

        // Packet with a gap before the tail: grant must be held with nothing to send.
        set_in(1'b1, mk(HDR, 12'd9), 1'b1, 1'b1);
        cyc();
        set_in(1'b1, mk(PAY, 12'd1), 1'b1, 1'b1);
        cyc();
        set_in(1'b0, '0, 1'b1, 1'b1);
        cyc();
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("gap_req", req, 1'b1);
            chk("gap_out_valid", out_valid, 1'b0);
            advance();
        end
        set_in(1'b1, mk(TL, 12'd2), 1'b1, 1'b1);
        cyc();
        set_in(1'b0, '0, 1'b1, 1'b1);
        sample();
        chk("gap_tail_ov", out_valid, 1'b1);
        advance();
        cyc();
        chk("gap_end_req", req, 1'b0);

        // Orphan payload while idle, then a long orphan run to saturate the counter.
        set_in(1'b1, mk(PAY, 12'd5), 1'b1, 1'b1);
        cyc();
        set_in(1'b0, '0, 1'b1, 1'b1);
        sample();
        chk("orphan_req", req, 1'b0);
        advance();
        cyc();
        chk("orphan_drop1", drop_count, 8'd1);
        for (int i = 0; i < 300; i++) begin
            set_in(1'b1, mk(PAY, 12'($urandom)), 1'b1, 1'b1);
            cyc();
        end
        set_in(1'b0, '0, 1'b1, 1'b1);
        cyc();
        cyc();
        chk("orphan_sat", drop_count, 8'd255);

        // Reset in the middle of a buffered packet.
        do_reset();
        set_in(1'b1, mk(HDR, 12'd4), 1'b0, 1'b1);
        cyc();
        set_in(1'b1, mk(PAY, 12'd0), 1'b0, 1'b1);
        cyc();
        cyc();
        rst = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b1);
        cyc();
        rst = 1'b0;
        sample();
        chk("midrst_occ", occupancy, 0);
        chk("midrst_req", req, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        advance();

        // Random packet stream, several times DEPTH flits, random backpressure and grant.
        src.delete();
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 7) == 0) src.push_back(mk($urandom_range(0, 1) ? PAY : TL, 12'd1));
            src.push_back(mk(HDR, ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom)));
            for (int k = $urandom_range(0, 4); k > 0; k--) src.push_back(mk(PAY, 12'($urandom)));
            src.push_back(mk(TL, 12'($urandom)));
        end
        idx = 0;
        for (int c = 0; c < 4000 && idx < src.size(); c++) begin
            set_in($urandom_range(0, 3) != 0, src[idx], $urandom_range(0, 7) != 0, 1'($urandom));
            sample();
            if (in_valid && e_inr) idx++;
            advance();
        end
        chk("stream_sent", idx, src.size());
        set_in(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 2 * DEPTH; i++) cyc();
        chk("stream_drained", occupancy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/input_port_buffer.md
INPUT_PORT_BUFFER -- requirements
Module: input_port_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, flit width in bits; SHALL be at least 16.
REQ-002 Parameter DEPTH, default 8, FIFO depth in flits; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_flit  input  DATA_WIDTH  upstream flit; bits [DW-1:DW-3] flit_id, header bits [11:0] packet length.
REQ-006 in_valid  input  1  upstream flit present.
REQ-007 in_ready  output  1  buffer can accept a flit this cycle.
REQ-008 grant  input  1  arbiter has selected this port.
REQ-009 out_ready  input  1  crossbar/downstream accepts a flit this cycle.
REQ-010 out_flit  output  DATA_WIDTH  FIFO head flit.
REQ-011 out_valid  output  1  out_flit valid for transfer.
REQ-012 req  output  1  request to arbiter.
REQ-013 flit_id  output  3  flit_id of head flit, 3'b000 when empty.
REQ-014 length  output  12  packet length for arbiter timer.
REQ-015 occupancy  output  $clog2(DEPTH)+1  flits stored.
REQ-016 drop_count  output  8  saturating count of discarded orphan flits.

Function
REQ-017 Storage SHALL be a circular FIFO; read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-018 in_ready SHALL equal (occupancy < DEPTH), from registered state only.
REQ-019 Push SHALL occur when in_valid && in_ready; a flit pushed into an empty FIFO SHALL appear at the head the following cycle (no bypass).
REQ-020 When full, no push SHALL occur even if a pop happens in the same cycle.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-022 flit_id encodings SHALL be the project `HEADER, `PAYLOAD, `TAIL defines.
REQ-023 Packet FSM SHALL have two states, IDLE and ACTIVE.
REQ-024 req SHALL be (state==ACTIVE) || (non-empty && head flit_id==`HEADER).
REQ-025 out_valid SHALL be req && grant && non-empty; transfer SHALL be out_valid && out_ready, popping one flit.
REQ-026 While ACTIVE with an empty FIFO, req SHALL stay 1 and out_valid SHALL be 0, holding the arbiter grant for the packet.
REQ-027 IDLE to ACTIVE SHALL occur on transfer of a `HEADER flit.
REQ-028 ACTIVE to IDLE SHALL occur on transfer of a `TAIL flit.
REQ-029 A `HEADER transferred while ACTIVE SHALL be forwarded normally, with the state staying ACTIVE and the length relatched.
REQ-030 In IDLE with a non-empty FIFO whose head is not `HEADER, that flit SHALL be popped without transfer and drop_count incremented, saturating at 255; req and out_valid SHALL be 0 that cycle.
REQ-031 length SHALL be head[11:0] when head flit_id==`HEADER, otherwise the registered len_q.
REQ-032 len_q SHALL load head[11:0] on each `HEADER transfer.
REQ-033 Length values SHALL be passed unmodified; 0 is legal.
REQ-034 grant without req SHALL have no effect.

Reset
REQ-035 On rst the block SHALL set pointers and occupancy to 0, state to IDLE, len_q to 0 and drop_count to 0.
REQ-036 During and directly after reset, outputs SHALL be: in_ready 1, req 0, out_valid 0, flit_id 0, length 0.
REQ-037 FIFO data contents SHALL need no reset.
REQ-038 rst mid-packet SHALL discard all stored flits and return to IDLE in the next cycle.

Verification
REQ-039 Push HEADER(len=3), PAYLOAD, PAYLOAD, TAIL with grant=out_ready=1 -> req rises one cycle after the header push, length=3 while the header is at the head, four transfers in order, then IDLE and req=0.
REQ-040 Push DEPTH flits with out_ready=0 -> in_ready=0, occupancy=DEPTH; then hold in_valid=1 with a single pop -> no push that cycle, occupancy DEPTH-1.
REQ-041 Send HEADER, PAYLOAD, then a gap of 5 idle cycles before TAIL -> req stays 1 through the gap, out_valid=0 during the gap, TAIL forwarded once pushed.
REQ-042 Push PAYLOAD with no preceding header while IDLE -> flit dropped, drop_count=1, req never asserts; 300 orphans -> drop_count=255.
REQ-043 Assert rst after a HEADER and 2 PAYLOADs are buffered -> next cycle occupancy=0, req=0, in_ready=1, state IDLE.
REQ-044 Run 3*DEPTH flits continuously with random out_ready -> data integrity holds across pointer wrap.
